// File: rtl/clkdiv_pkg.sv
// Shared constants for the board-clock divider family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clkdiv_pkg;

    localparam int DEF_CNT_W = 26;
    localparam int unsigned SYS_CLK_HZ = 50_000_000;

    function automatic int unsigned half_from_hz(input int unsigned hz);
        return SYS_CLK_HZ / (2 * hz);
    endfunction

    localparam int unsigned HALF_500HZ = 50_000;
    localparam int unsigned HALF_1HZ   = 25_000_000;

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: half-period counter, square output, tick/rise strobes, pending half-period.
// Latency: outputs registered, strobes one clock after terminal count; config applied at next terminal.
// Backpressure: pend high means a new half-period is waiting; the top refuses further loads until it clears.
module clock_divider_channel #(
    parameter int               CNT_W    = 26,
    parameter logic [CNT_W-1:0] DEF_HALF = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_half,
    output logic             pend,
    output logic             clk_out,
    output logic             tick,
    output logic             rise
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] pend_half;
    logic [CNT_W-1:0] nxt_half;
    logic             running;
    logic             term;
    logic             nxt_clk;

    // ">=" rather than "==" so a smaller half applied while paused cannot wrap the counter
    always_comb begin
        running  = en && (half != '0);
        term     = running && (cnt >= half - CNT_W'(1));
        nxt_half = pend ? pend_half : half;
        nxt_clk  = (nxt_half == '0) ? 1'b0 : ~clk_out;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            half      <= DEF_HALF;
            pend_half <= '0;
            pend      <= 1'b0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            rise      <= 1'b0;
        end else if (sync) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            rise    <= 1'b0;
            half    <= load ? load_half : nxt_half;
            pend    <= 1'b0;
        end else if (!running) begin
            // paused or stopped: nothing to keep glitch-free, so take new values at once
            tick <= 1'b0;
            rise <= 1'b0;
            half <= load ? load_half : nxt_half;
            pend <= 1'b0;
            if (half == '0) begin
                cnt     <= '0;
                clk_out <= 1'b0;
            end
        end else if (term) begin
            cnt     <= '0;
            clk_out <= nxt_clk;
            tick    <= 1'b1;
            rise    <= nxt_clk;
            half    <= nxt_half;
            pend    <= load;
            if (load) begin
                pend_half <= load_half;
            end
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
            rise <= 1'b0;
            if (load) begin
                pend      <= 1'b1;
                pend_half <= load_half;
            end
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// N_CH independent square-wave dividers off the board clock with runtime half-period config and global sync.
// Latency: config takes effect at the target channel's next terminal count (at most the old half-period).
// Backpressure: cfg_ready low while the addressed channel already holds a pending half-period.
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int                      N_CH     = 2,
    parameter int                      CNT_W    = DEF_CNT_W,
    parameter logic [N_CH*CNT_W-1:0]   DEF_HALF = {CNT_W'(HALF_1HZ), CNT_W'(HALF_500HZ)},
    parameter int                      CH_W     = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  rise
);

    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] load;
    logic            xfer;

    // out-of-range channel indices match nothing, so they are accepted and dropped
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pend[i];
            end
        end
    end

    assign xfer = cfg_valid && cfg_ready;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign load[g] = xfer && (cfg_ch == CH_W'(g));

        clock_divider_channel #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF[g*CNT_W +: CNT_W])
        ) u_ch (
            .clock     (clock),
            .reset_n   (reset_n),
            .en        (en[g]),
            .sync      (sync),
            .load      (load[g]),
            .load_half (cfg_half),
            .pend      (pend[g]),
            .clk_out   (clk_out[g]),
            .tick      (tick[g]),
            .rise      (rise[g])
        );
    end

endmodule
